max_pool_multi: RTL
===================

# max_pool_multi

Max-pooling stage sitting directly downstream of the multi-filter convolution layer. On a `start` pulse it captures the full flat feature-map vector of K channels × H × W half-precision values, then computes non-overlapping P×P max pools at one output element per clock, with an optional ReLU clamp. It pulses `Finished` when the whole pooled vector is valid. Its `start` is driven by the convolution layer's `Finished` pulse, and its output feeds the next convolution or fully-connected stage.

## Interface
- `K`, 6: number of channels (feature maps) in the input vector.
- `H`, 28: input feature-map height.
- `W`, 28: input feature-map width.
- `P`, 2: pool window size and stride (square, non-overlapping).
- `RELU`, 0: 1 enables the output clamp `max(x, +0)`; 0 passes pooled values unchanged.
- Derived values:
  - DATA_WIDTH = 16 (localparam, IEEE-754 binary16).
  - Ho = H/P and Wo = W/P (floor division; trailing rows and columns are dropped).
  - N = K·Ho·Wo.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `start` input 1: one-cycle request to capture `inputConv` and begin pooling.
- `inputConv` input [0:K·H·W·16-1]: element (k,r,c) is at `[((k·H+r)·W+c)·16 +: 16]`.
- `outputPool` output reg [0:N·16-1]: element (k,i,j) is at `[((k·Ho+i)·Wo+j)·16 +: 16]`.
- `busy` output reg 1: high while capturing or pooling.
- `Finished` output reg 1: one-cycle pulse when `outputPool` is complete.

## Operation
- FSM has two states: IDLE and RUN.
- IDLE:
  - `start`=1 at a rising edge copies `inputConv` into an internal capture buffer.
  - The same edge sets `busy`=1, clears index counters (k,i,j) to 0 and enters RUN.
  - Upstream may change `inputConv` freely after the capture edge.
- RUN:
  - Each edge computes the max of the P×P window at rows i·P..i·P+P-1 and columns j·P..j·P+P-1 of channel k, from the capture buffer.
  - The result (after optional ReLU) is written into the `outputPool` slice for (k,i,j).
  - Counters then advance j fastest, then i, then k.
- Last element (k=K-1, i=Ho-1, j=Wo-1):
  - The write edge also sets `Finished`=1 and `busy`=0, and the FSM returns to IDLE.
  - `Finished` clears on the next edge.
- Compare rule: map each value x to an unsigned key.
  - Sign 0: key = x ^ 0x8000.
  - Sign 1: key = ~x.
  - The window element with the largest key wins. On equal keys the earliest in row-major window order wins; the bit pattern is identical either way.
  - Ordering consequence: -0 (0x8000) < +0 (0x0000). NaN/Inf are not special-cased and order by key.
- ReLU (RELU=1): any winner with sign bit 1 is replaced by 0x0000.
- `start` during RUN is ignored and does not restart the run.
- `outputPool` elements keep their last value until rewritten; they are not cleared on `start`.

## Timing
- Reset values: `outputPool`=0, `busy`=0, `Finished`=0, state IDLE, counters 0, capture buffer 0.
- Capture edge E0 is the first edge with `start`=1 in IDLE. `busy` is high after E0.
- Element n (0..N-1) is written at edge E(n+1).
- `Finished` is high for exactly the cycle following edge EN, i.e. N clocks after E0. `busy` is low in that same cycle.
- Throughput: a new `start` is accepted at any edge from EN+1 onward. A `start` that is high at EN is ignored.
- Reset asserted mid-RUN:
  - Immediately clears all outputs and returns to IDLE.
  - No `Finished` pulse is produced for the aborted run.
- Default parameters: N = 6·14·14 = 1176 cycles from capture to `Finished`.

## Test plan
- **Basic pool.** K=1, H=W=4, P=2, RELU=0. Top-left window {0x3C00, 0x4000, 0x3800, 0xBC00}, other windows all 0x3800; pulse `start` → `outputPool` = {0x4000, 0x3800, 0x3800, 0x3800}, `Finished` one cycle exactly 4 clocks after the capture edge, `busy` high for those 4 cycles.
- **Negative and signed-zero ordering.** Window {0xC000, 0xBC00, 0x8000, 0xC400} → 0x8000. Window {0x8000, 0x0000, 0x8000, 0x8000} → 0x0000.
- **ReLU enabled.** RELU=1, window {0xC000, 0xBC00, 0xC400, 0xC200} → 0x0000. Window {0xBC00, 0x3800, 0xC000, 0xC000} → 0x3800.
- **Capture and ignored start.** Change `inputConv` to all 0x4000 one cycle after capture, and pulse `start` mid-RUN → results reflect the captured data only, `Finished` timing is unchanged, and exactly one `Finished` pulse occurs.
- **Odd dims and multi-channel.** K=2, H=W=5, P=2 → Ho=Wo=2, N=8. Row 4 and column 4 are ignored (set them to 0x7BFF to prove it), and channel 1 results land at slices 4..7.
- **Reset mid-run and back-to-back.** Assert `reset` at cycle 2 of RUN → `outputPool`=0, `busy`=0, no `Finished` pulse. Then run twice with `start` at EN+1 → two `Finished` pulses spaced exactly N+1 clocks apart.

Source files
------------

// File: rtl/max_pool_multi.sv
// Non-overlapping PxP max-pool over a captured K x H x W binary16 feature map,
// one pooled element per clock, with optional ReLU clamp on the winner.
module max_pool_multi #(
    parameter int K    = 6,
    parameter int H    = 28,
    parameter int W    = 28,
    parameter int P    = 2,
    parameter int RELU = 0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [0:K*H*W*16-1]            inputConv,
    output logic [0:K*(H/P)*(W/P)*16-1]    outputPool,
    output logic                           busy,
    output logic                           Finished
);
    localparam int DATA_WIDTH = 16;
    localparam int HO = H / P;
    localparam int WO = W / P;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int IW = (HO > 1) ? $clog2(HO) : 1;
    localparam int JW = (WO > 1) ? $clog2(WO) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(K - 1);
    localparam logic [IW-1:0] I_LAST = IW'(HO - 1);
    localparam logic [JW-1:0] J_LAST = JW'(WO - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state, state_nxt;
    logic [0:K*H*W*16-1]      cap;
    logic [KW-1:0]            k_idx;
    logic [IW-1:0]            i_idx;
    logic [JW-1:0]            j_idx;
    logic                     last, capture_en, write_en, done;
    logic [DATA_WIDTH-1:0]    elem, win_val, pool_val;
    int                       out_base;

    // Monotonic key: larger key means larger float, with -0 below +0.
    function automatic logic [15:0] key_of(input logic [15:0] x);
        return x[15] ? ~x : (x ^ 16'h8000);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last)  state_nxt = IDLE;
            default:         state_nxt = IDLE;
        endcase
    end

    always_comb begin
        last       = (k_idx == K_LAST) && (i_idx == I_LAST) && (j_idx == J_LAST);
        capture_en = (state == IDLE) && start;
        write_en   = (state == RUN);
        done       = write_en && last;
    end

    // Strict greater-than keeps the earliest row-major element on ties.
    always_comb begin
        elem    = '0;
        win_val = '0;
        for (int r = 0; r < P; r++) begin
            for (int c = 0; c < P; c++) begin
                elem = cap[((int'(k_idx) * H + int'(i_idx) * P + r) * W
                            + int'(j_idx) * P + c) * DATA_WIDTH +: DATA_WIDTH];
                if ((r == 0 && c == 0) || key_of(elem) > key_of(win_val))
                    win_val = elem;
            end
        end
        pool_val = (RELU != 0 && win_val[15]) ? 16'h0000 : win_val;
        out_base = ((int'(k_idx) * HO + int'(i_idx)) * WO + int'(j_idx)) * DATA_WIDTH;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap        <= '0;
            outputPool <= '0;
            busy       <= 1'b0;
            Finished   <= 1'b0;
            k_idx      <= '0;
            i_idx      <= '0;
            j_idx      <= '0;
        end else begin
            Finished <= done;
            if (capture_en) begin
                cap   <= inputConv;
                busy  <= 1'b1;
                k_idx <= '0;
                i_idx <= '0;
                j_idx <= '0;
            end
            if (write_en) begin
                outputPool[out_base +: DATA_WIDTH] <= pool_val;
                busy <= !last;
                if (j_idx == J_LAST) begin
                    j_idx <= '0;
                    if (i_idx == I_LAST) begin
                        i_idx <= '0;
                        k_idx <= (k_idx == K_LAST) ? '0 : k_idx + 1'b1;
                    end else begin
                        i_idx <= i_idx + 1'b1;
                    end
                end else begin
                    j_idx <= j_idx + 1'b1;
                end
            end
        end
    end
endmodule
